// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared types and constants for the intersection sequencer.
//                - state_t : phase enumeration, fixed 3-bit encodings
//                - LIGHT_* : 3-bit light vectors in {red, ylw, grn} order
//                - light_decode : state -> {ns[2:0], ew[2:0]} light vector
//  Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5
  } state_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YLW = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // Result is {ns_red, ns_ylw, ns_grn, ew_red, ew_ylw, ew_grn}. Unused
  // encodings fall back to all-red so a corrupted state can never show green.
  function automatic logic [5:0] light_decode(input state_t s);
    logic [5:0] v;
    v = {LIGHT_RED, LIGHT_RED};
    case (s)
      NS_GREEN:  v = {LIGHT_GRN, LIGHT_RED};
      NS_YELLOW: v = {LIGHT_YLW, LIGHT_RED};
      EW_GREEN:  v = {LIGHT_RED, LIGHT_GRN};
      EW_YELLOW: v = {LIGHT_RED, LIGHT_YLW};
      default:   v = {LIGHT_RED, LIGHT_RED};
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intersection_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_sequencer_if
//  Description : Request/sensor inputs and light/phase outputs of the
//                intersection sequencer.
//                master : the sequencer (drives lights and phase)
//                slave  : the environment (drives tick, sensor, requests)
//  Revision    : 1.0  initial release
// ============================================================================
interface intersection_sequencer_if;
  logic       tick;
  logic       sensor_ew;
  logic       ped_req_ns;
  logic       ped_req_ew;
  logic       ns_red;
  logic       ns_ylw;
  logic       ns_grn;
  logic       ew_red;
  logic       ew_ylw;
  logic       ew_grn;
  logic [2:0] phase;

  modport master (
    input  tick, sensor_ew, ped_req_ns, ped_req_ew,
    output ns_red, ns_ylw, ns_grn, ew_red, ew_ylw, ew_grn, phase
  );

  modport slave (
    output tick, sensor_ew, ped_req_ns, ped_req_ew,
    input  ns_red, ns_ylw, ns_grn, ew_red, ew_ylw, ew_grn, phase
  );
endinterface
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : TIMER_W-bit tick counter with synchronous clear and
//                saturation at all-ones.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_clear       - force count to 0 (wins over i_tick)
//                i_tick        - advance count by one
//                o_count       - current count
//  Revision    : 1.0  initial release
// ============================================================================
module phase_timer #(
  parameter int TIMER_W = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_clear,
  input  wire logic               i_tick,
  output logic      [TIMER_W-1:0] o_count
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_tick && (r_count != {TIMER_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/intersection_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_sequencer
//  Description : Phase sequencer for a two-road intersection. Rests on
//                north-south green, serves east-west on sensor or latched
//                pedestrian request; pending pedestrian requests shorten the
//                opposing green down to MIN_GREEN_TICKS.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - master side of intersection_sequencer_if
//                           (tick, sensor_ew, ped_req_* in; lights, phase out)
//  Revision    : 1.0  initial release
// ============================================================================
module intersection_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS     = 20,
  parameter int MIN_GREEN_TICKS = 8,
  parameter int YELLOW_TICKS    = 4,
  parameter int ALL_RED_TICKS   = 2,
  parameter int TIMER_W         = 8
) (
  input wire logic              clk,
  input wire logic              rst,
  intersection_sequencer_if.master bus
);

  // "Reaches N" = tick this cycle with count already at N-1 or beyond.
  localparam logic [TIMER_W-1:0] c_GREEN_LAST  = TIMER_W'(GREEN_TICKS - 1);
  localparam logic [TIMER_W-1:0] c_MIN_LAST    = TIMER_W'(MIN_GREEN_TICKS - 1);
  localparam logic [TIMER_W-1:0] c_YELLOW_LAST = TIMER_W'(YELLOW_TICKS - 1);
  localparam logic [TIMER_W-1:0] c_ALLRED_LAST = TIMER_W'(ALL_RED_TICKS - 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_change;
  logic [TIMER_W-1:0] w_count;
  logic               r_pend_ns;
  logic               r_pend_ew;
  logic [5:0]         r_lights;

  phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_change),
    .i_tick  (bus.tick),
    .o_count (w_count)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      NS_GREEN: begin
        // Full green needs any EW demand; a latched EW pedestrian request
        // may cut it short at the minimum green.
        if (bus.tick &&
            (((w_count >= c_GREEN_LAST) && (bus.sensor_ew || r_pend_ew)) ||
             ((w_count >= c_MIN_LAST) && r_pend_ew))) begin
          w_next = NS_YELLOW;
        end
      end
      NS_YELLOW: if (bus.tick && (w_count >= c_YELLOW_LAST)) w_next = ALL_RED_A;
      ALL_RED_A: if (bus.tick && (w_count >= c_ALLRED_LAST)) w_next = EW_GREEN;
      EW_GREEN: begin
        if (bus.tick &&
            ((w_count >= c_GREEN_LAST) ||
             ((w_count >= c_MIN_LAST) && r_pend_ns))) begin
          w_next = EW_YELLOW;
        end
      end
      EW_YELLOW: if (bus.tick && (w_count >= c_YELLOW_LAST)) w_next = ALL_RED_B;
      ALL_RED_B: if (bus.tick && (w_count >= c_ALLRED_LAST)) w_next = NS_GREEN;
      default:   w_next = ALL_RED_B;
    endcase
  end

  assign w_change = (w_next != r_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ALL_RED_B;
    end else begin
      r_state <= w_next;
    end
  end

  // Lights are registered from the next state so they switch on the same
  // edge as the state register, with no combinational glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lights <= light_decode(ALL_RED_B);
    end else begin
      r_lights <= light_decode(w_next);
    end
  end

  // Clear on entry to the serving green takes priority over a new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_ns <= 1'b0;
      r_pend_ew <= 1'b0;
    end else begin
      if ((w_next == NS_GREEN) && (r_state != NS_GREEN)) begin
        r_pend_ns <= 1'b0;
      end else if (bus.ped_req_ns) begin
        r_pend_ns <= 1'b1;
      end
      if ((w_next == EW_GREEN) && (r_state != EW_GREEN)) begin
        r_pend_ew <= 1'b0;
      end else if (bus.ped_req_ew) begin
        r_pend_ew <= 1'b1;
      end
    end
  end

  assign bus.ns_red = r_lights[5];
  assign bus.ns_ylw = r_lights[4];
  assign bus.ns_grn = r_lights[3];
  assign bus.ew_red = r_lights[2];
  assign bus.ew_ylw = r_lights[1];
  assign bus.ew_grn = r_lights[0];
  assign bus.phase  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_intersection_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intersection_sequencer
//  Description : Self-checking bench for intersection_sequencer. A behavioural
//                model predicts phase and lights each cycle (scoreboard queue);
//                a vector table and hand sequences check phase checkpoints.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_intersection_sequencer;

  localparam int G  = 20;
  localparam int M  = 8;
  localparam int Y  = 4;
  localparam int AR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  intersection_sequencer_if bus();

  intersection_sequencer #(
    .GREEN_TICKS     (G),
    .MIN_GREEN_TICKS (M),
    .YELLOW_TICKS    (Y),
    .ALL_RED_TICKS   (AR),
    .TIMER_W         (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0] phase;
    logic [5:0] lights;
  } exp_t;

  typedef struct {
    string      name;
    bit         rst_first;
    bit         sensor;
    int         ncyc;
    logic [2:0] exp_phase;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state
  logic [2:0] m_state;
  int         m_cnt;
  bit         m_pns;
  bit         m_pew;

  function automatic logic [5:0] lights_of(input logic [2:0] p);
    case (p)
      3'd0:    return 6'b001_100;
      3'd1:    return 6'b010_100;
      3'd3:    return 6'b100_001;
      3'd4:    return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic check_val(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    logic [5:0] l;
    l = {bus.ns_red, bus.ns_ylw, bus.ns_grn, bus.ew_red, bus.ew_ylw, bus.ew_grn};
    if (sb.size() == 0) begin
      check_val("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check_val("sb_phase", int'(bus.phase), int'(e.phase));
    check_val("sb_lights", int'(l), int'(e.lights));
    check_val("safety", int'(!bus.ns_red && !bus.ew_red), 0);
    check_val("ns_onehot", $countones(l[5:3]), 1);
    check_val("ew_onehot", $countones(l[2:0]), 1);
  endtask

  task automatic step(input bit t, input bit s, input bit pn, input bit pe);
    logic [2:0] nxt;
    int c;
    exp_t e;
    rst            = 1'b0;
    bus.tick       = t;
    bus.sensor_ew  = s;
    bus.ped_req_ns = pn;
    bus.ped_req_ew = pe;
    nxt = m_state;
    c   = m_cnt + (t ? 1 : 0);
    case (m_state)
      3'd0: if (t && ((c >= G && (s || m_pew)) || (c >= M && m_pew))) nxt = 3'd1;
      3'd1: if (t && c >= Y)  nxt = 3'd2;
      3'd2: if (t && c >= AR) nxt = 3'd3;
      3'd3: if (t && (c >= G || (c >= M && m_pns))) nxt = 3'd4;
      3'd4: if (t && c >= Y)  nxt = 3'd5;
      default: if (t && c >= AR) nxt = 3'd0;
    endcase
    m_pns   = (nxt == 3'd0 && m_state != 3'd0) ? 1'b0 : (m_pns | pn);
    m_pew   = (nxt == 3'd3 && m_state != 3'd3) ? 1'b0 : (m_pew | pe);
    m_cnt   = (nxt != m_state) ? 0 : c;
    m_state = nxt;
    e.phase  = nxt;
    e.lights = lights_of(nxt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    exp_t e;
    rst            = 1'b1;
    bus.tick       = 1'b1;
    bus.sensor_ew  = 1'b0;
    bus.ped_req_ns = 1'b0;
    bus.ped_req_ew = 1'b0;
    m_state = 3'd5;
    m_cnt   = 0;
    m_pns   = 1'b0;
    m_pew   = 1'b0;
    e.phase  = 3'd5;
    e.lights = 6'b100_100;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic run_until(input string nm, input logic [2:0] ph, input bit s, input int budget);
    for (int i = 0; i < budget && bus.phase != ph; i++) step(1'b1, s, 1'b0, 1'b0);
    check_val(nm, int'(bus.phase), int'(ph));
  endtask

  task automatic ticks(input int n, input bit s);
    for (int i = 0; i < n; i++) step(1'b1, s, 1'b0, 1'b0);
  endtask

  vec_t vecs[17];

  initial begin
    rst            = 1'b1;
    bus.tick       = 1'b0;
    bus.sensor_ew  = 1'b0;
    bus.ped_req_ns = 1'b0;
    bus.ped_req_ew = 1'b0;

    vecs[0]  = '{"idle_allred",      1'b1, 1'b0, 1,  3'd5};
    vecs[1]  = '{"idle_ns_entry",    1'b0, 1'b0, 1,  3'd0};
    vecs[2]  = '{"idle_rest",        1'b0, 1'b0, 98, 3'd0};
    vecs[3]  = '{"sens_allred",      1'b1, 1'b1, 1,  3'd5};
    vecs[4]  = '{"sens_ns_entry",    1'b0, 1'b1, 1,  3'd0};
    vecs[5]  = '{"sens_ns_19",       1'b0, 1'b1, 19, 3'd0};
    vecs[6]  = '{"sens_nsy_entry",   1'b0, 1'b1, 1,  3'd1};
    vecs[7]  = '{"sens_nsy_3",       1'b0, 1'b1, 3,  3'd1};
    vecs[8]  = '{"sens_ara_entry",   1'b0, 1'b1, 1,  3'd2};
    vecs[9]  = '{"sens_ara_1",       1'b0, 1'b1, 1,  3'd2};
    vecs[10] = '{"sens_ew_entry",    1'b0, 1'b1, 1,  3'd3};
    vecs[11] = '{"sens_ew_19",       1'b0, 1'b1, 19, 3'd3};
    vecs[12] = '{"sens_ewy_entry",   1'b0, 1'b1, 1,  3'd4};
    vecs[13] = '{"sens_ewy_3",       1'b0, 1'b1, 3,  3'd4};
    vecs[14] = '{"sens_arb_entry",   1'b0, 1'b1, 1,  3'd5};
    vecs[15] = '{"sens_arb_1",       1'b0, 1'b1, 1,  3'd5};
    vecs[16] = '{"sens_ns_return",   1'b0, 1'b1, 1,  3'd0};

    for (int v = 0; v < 17; v++) begin
      if (vecs[v].rst_first) do_reset();
      ticks(vecs[v].ncyc, vecs[v].sensor);
      check_val(vecs[v].name, int'(bus.phase), int'(vecs[v].exp_phase));
    end

    // EW pedestrian pulse on NS-green tick 3 cuts green at the minimum.
    do_reset();
    ticks(2, 1'b0);
    check_val("pew_ns_entry", int'(bus.phase), 0);
    ticks(2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    ticks(4, 1'b0);
    check_val("pew_tick7", int'(bus.phase), 0);
    ticks(1, 1'b0);
    check_val("pew_min_exit", int'(bus.phase), 1);
    run_until("pew_to_ew", 3'd3, 1'b0, 20);
    run_until("pew_back_ns", 3'd0, 1'b0, 40);
    ticks(30, 1'b0);
    check_val("pew_cleared_rest", int'(bus.phase), 0);

    // NS request coincident with NS-green entry is dropped.
    do_reset();
    ticks(1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_val("pns_ns_entry", int'(bus.phase), 0);
    run_until("pns_to_ew", 3'd3, 1'b1, 40);
    ticks(19, 1'b0);
    check_val("pns_ew_19", int'(bus.phase), 3);
    ticks(1, 1'b0);
    check_val("pns_ew_20", int'(bus.phase), 4);

    // tick held low mid EW green freezes the dwell.
    do_reset();
    run_until("frz_to_ew", 3'd3, 1'b1, 40);
    ticks(10, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("frz_hold", int'(bus.phase), 3);
    ticks(9, 1'b0);
    check_val("frz_resume_19", int'(bus.phase), 3);
    ticks(1, 1'b0);
    check_val("frz_resume_20", int'(bus.phase), 4);

    // Reset in the middle of EW yellow goes straight to all-red.
    ticks(2, 1'b0);
    check_val("rst_mid_ewy", int'(bus.phase), 4);
    do_reset();
    check_val("rst_phase", int'(bus.phase), 5);
    check_val("rst_lights", int'({bus.ns_red, bus.ns_ylw, bus.ns_grn,
                                  bus.ew_red, bus.ew_ylw, bus.ew_grn}), 6'b100100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog timeout");
  end

endmodule
`default_nettype wire

// File: doc/intersection_sequencer.md
# intersection_sequencer

Master phase sequencer for a two-road intersection (north-south main road, east-west side road). It drives the red/yellow/green traffic-light lines that feed the pedestrian crosswalk units. It rests on north-south green and serves east-west on a vehicle sensor or a latched pedestrian request. Pedestrian requests also shorten the opposing green down to a guaranteed minimum.

## Interface
- GREEN_TICKS, 20, nominal green duration in ticks (>=1)
- MIN_GREEN_TICKS, 8, minimum green before early termination (1..GREEN_TICKS)
- YELLOW_TICKS, 4, yellow duration in ticks (>=1)
- ALL_RED_TICKS, 2, all-red clearance duration in ticks (>=1)
- TIMER_W, 8, phase timer width; every duration must be < 2^TIMER_W
- clk  input  1  system clock, all logic on posedge
- rst  input  1  reset, synchronous, active-high
- tick  input  1  one-cycle timebase enable; the timer advances only on cycles with tick=1
- sensor_ew  input  1  level, vehicle waiting on the east-west road
- ped_req_ns  input  1  pulse or level, request to cross parallel to north-south (served by NS green)
- ped_req_ew  input  1  request to cross parallel to east-west (served by EW green)
- ns_red, ns_ylw, ns_grn  output  1 each  north-south lights, exactly one high at all times
- ew_red, ew_ylw, ew_grn  output  1 each  east-west lights, exactly one high at all times
- phase  output  3  current state encoding, for debug and bench checks

## Operation
- States, cycled in this order: NS_GREEN -> NS_YELLOW -> ALL_RED_A -> EW_GREEN -> EW_YELLOW -> ALL_RED_B -> NS_GREEN.
- Light decode by state:
  - NS_GREEN: ns_grn, ew_red
  - NS_YELLOW: ns_ylw, ew_red
  - ALL_RED_A and ALL_RED_B: both red
  - EW_GREEN: ew_grn, ns_red
  - EW_YELLOW: ew_ylw, ns_red
- Safety invariant: ns and ew are never both non-red.
- Request latches:
  - pend_ns is set by ped_req_ns and cleared on entry to NS_GREEN.
  - pend_ew is set by ped_req_ew and cleared on entry to EW_GREEN.
  - If set and clear occur in the same cycle, clear wins. The crosswalk holds its own request.
- Phase timer:
  - Cleared to 0 on every state change.
  - Otherwise increments on tick, saturating at 2^TIMER_W-1.
  - "Reaches N" means tick=1 and timer >= N-1.
- Transitions:
  - NS_GREEN -> NS_YELLOW when either:
    - timer reaches GREEN_TICKS and (sensor_ew or pend_ew), or
    - timer reaches MIN_GREEN_TICKS and pend_ew.
  - With no east-west demand, NS_GREEN holds indefinitely (rest state).
  - EW_GREEN -> EW_YELLOW when timer reaches GREEN_TICKS, or when timer reaches MIN_GREEN_TICKS and pend_ns. EW_GREEN never rests.
  - Yellow states advance when timer reaches YELLOW_TICKS.
  - All-red states advance when timer reaches ALL_RED_TICKS.
- Reset:
  - State is ALL_RED_B, timer 0, pend_ns = pend_ew = 0.
  - Outputs: ns_red = ew_red = 1, all other lights 0, phase = ALL_RED_B encoding.
  - Reset mid-phase aborts immediately to this condition. No yellow is shown.

## Timing
- State, timer, latches and all outputs are registered. Outputs are decoded from the next-state value, so lights change on the same clk edge as state; there is no extra cycle of lag.
- A transition takes effect on the clk edge of the qualifying tick cycle. Phase dwell is exactly N ticks, except for a held NS_GREEN.
- Request capture: a request asserted in cycle k is visible to the transition logic in cycle k+1.
- Light lines are glitch-free registered levels. The crosswalk's posedge detection on green and red relies on this.
- tick=0 freezes the timer. Requests and sensor are still sampled every cycle.
- sensor_ew is not latched. If it drops before GREEN_TICKS is reached, NS_GREEN keeps resting.

## Structure
- Shared package `traffic_pkg`:
  - state enum and 3-bit encodings (NS_GREEN=0 … ALL_RED_B=5)
  - 3-bit light vector constants LIGHT_RED/LIGHT_YLW/LIGHT_GRN, in {red,ylw,grn} order
- Sub-module `phase_timer`:
  - TIMER_W-wide tick counter with synchronous clear and saturation
  - exposes count only; threshold compares stay in the sequencer
- Remaining logic is one FSM, two request latches and the output decode.

## Test plan
- Reset then idle, GREEN_TICKS=20, no requests, 100 ticks: after 2 ticks (ALL_RED_B) NS green holds for the rest of the run; ew_red stays high.
- sensor_ew held high from reset: NS green for 20 ticks, yellow 4, all-red 2, EW green 20, yellow 4, all-red 2, back to NS green.
- ped_req_ew pulsed at NS-green tick 3: NS_YELLOW entered on tick 8 (MIN_GREEN_TICKS); pend_ew clears on EW_GREEN entry.
- ped_req_ns pulse in the same cycle as entry to NS_GREEN: pend_ns stays 0 (clear wins); the next EW green runs the full 20 ticks.
- tick held low for 50 cycles mid EW_GREEN: no state change, timer frozen; dwell resumes exactly where it stopped.
- rst asserted mid EW_YELLOW: next edge shows phase=ALL_RED_B and both reds. Every cycle of every test asserts the safety invariant and one-hot lights per direction.
